// File: rtl/mips32_mul_unit.sv
// Iterative shift-add multiplier with unsigned/signed modes: one multiplier bit per cycle, done pulses WIDTH+1 cycles after start.
// No backpressure: start is accepted only in IDLE or DONE and ignored while busy; results hold until the next completion.
module mips32_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH:0]       mplier_q;
  logic [WIDTH:0]       a_ext;
  logic [WIDTH:0]       b_ext;
  logic [WIDTH:0]       a_mag;
  logic [WIDTH:0]       b_mag;
  logic [CW-1:0]        cnt_q;
  logic                 sign_q;
  logic                 sign_d;
  logic                 signed_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  // Operands widened by one bit so the magnitude of the most negative value is exact.
  always_comb begin
    a_ext  = {signed_op & a[WIDTH-1], a};
    b_ext  = {signed_op & b[WIDTH-1], b};
    a_mag  = a_ext[WIDTH] ? -a_ext : a_ext;
    b_mag  = b_ext[WIDTH] ? -b_ext : b_ext;
    sign_d = a_ext[WIDTH] ^ b_ext[WIDTH];
    acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod_d = sign_q ? -acc_d : acc_d;
    if (signed_q) begin
      ovf_d = (prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}});
    end else begin
      ovf_d = |prod_d[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= {{(WIDTH-1){1'b0}}, a_mag};
            mplier_q <= b_mag;
            sign_q   <= sign_d;
            signed_q <= signed_op;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            ovf_q   <= ovf_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mips32_mul_unit.sv
// Bench for mips32_mul_unit: directed and random multiplies checked against a 64-bit arithmetic reference,
// plus latency, done-pulse width, result hold, ignored start, back-to-back start and mid-run reset.
module tb_mips32_mul_unit;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;
  logic        prev_ovf = 1'b0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  mips32_mul_unit #(.WIDTH(32)) dut (
    .clk1(clk1), .reset(reset), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .lo(lo), .hi(hi), .ovf(ovf)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk1);
    lat++;
  endtask

  // Reference: full-precision product from native 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    longint     sa, sb, sp;
    logic [63:0] p;
    logic        o;
    if (is) begin
      sa = longint'($signed(ia));
      sb = longint'($signed(ib));
      sp = sa * sb;
      p  = 64'(sp);
      o  = (sp > MAXV) || (sp < MINV);
    end else begin
      p = {32'd0, ia} * {32'd0, ib};
      o = (p[63:32] != 32'd0);
    end
    return {o, p};
  endfunction

  task automatic launch(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    a = ia; b = ib; signed_op = is; start = 1'b1;
    lat = -1;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom; signed_op = 1'($urandom);
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("hold_lo_start", lo, prev_lo);
    chk("hold_hi_start", hi, prev_hi);
  endtask

  task automatic finish_op(input logic [31:0] ia, input logic [31:0] ib, input logic is);
    logic [64:0] m;
    m = model(ia, ib, is);
    while (done !== 1'b1 && lat < 40) begin
      chk("busy_in_run", busy, 1);
      if (lat == 16) begin
        chk("hold_lo_run", lo, prev_lo);
        chk("hold_ovf_run", ovf, prev_ovf);
      end
      step();
    end
    chk("latency", lat, 32);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("lo", lo, m[31:0]);
    chk("hi", hi, m[63:32]);
    chk("ovf", ovf, m[64]);
    prev_lo = m[31:0]; prev_hi = m[63:32]; prev_ovf = m[64];
  endtask

  task automatic pulse_end();
    step();
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("hold_lo_idle", lo, prev_lo);
  endtask

  initial begin
    logic [31:0] ra, rb, chain;
    logic        rs;
    int          dseen;

    reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    @(negedge clk1);
    start = 1'b1; a = 32'd77; b = 32'd99;
    @(negedge clk1);
    @(negedge clk1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lo", lo, 0);
    chk("rst_hi", hi, 0);
    chk("rst_ovf", ovf, 0);

    // First start coincides with the first low-reset edge.
    reset = 1'b0;
    launch(32'd27, 32'd3, 1'b0);
    finish_op(32'd27, 32'd3, 1'b0);
    chk("u27x3_lo", lo, 81);
    pulse_end();

    launch(32'hFFFFFFF9, 32'd6, 1'b1);
    finish_op(32'hFFFFFFF9, 32'd6, 1'b1);
    chk("s_m7x6_lo", lo, 32'hFFFFFFD6);
    chk("s_m7x6_hi", hi, 32'hFFFFFFFF);
    pulse_end();

    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    finish_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("u_max_hi", hi, 32'hFFFFFFFE);
    chk("u_max_ovf", ovf, 1);
    pulse_end();

    launch(32'h80000000, 32'hFFFFFFFF, 1'b1);
    finish_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    chk("s_minneg_lo", lo, 32'h80000000);
    chk("s_minneg_ovf", ovf, 1);
    pulse_end();

    // Start during RUN is ignored; then a back-to-back start in the DONE cycle.
    launch(32'd5, 32'd5, 1'b0);
    while (lat < 10) step();
    start = 1'b1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    finish_op(32'd5, 32'd5, 1'b0);
    chk("ignored_start_lo", lo, 25);
    launch(32'd2, 32'd3, 1'b0);
    finish_op(32'd2, 32'd3, 1'b0);
    chk("b2b_lo", lo, 6);
    pulse_end();

    // Mid-run reset aborts with no completion.
    launch(32'd123, 32'd456, 1'b0);
    while (lat < 15) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_lo", lo, 0);
    chk("abort_hi", hi, 0);
    dseen = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) dseen++;
    end
    chk("abort_no_done", dseen, 0);
    prev_lo = '0; prev_hi = '0; prev_ovf = 1'b0;
    launch(32'd1000, 32'd1000, 1'b0);
    finish_op(32'd1000, 32'd1000, 1'b0);
    pulse_end();

    chain = 32'd1;
    for (int k = 0; k < 4; k++) begin
      launch(chain, 32'd3, 1'b0);
      finish_op(chain, 32'd3, 1'b0);
      chain = lo;
      pulse_end();
    end
    chk("power_chain", chain, 81);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      case ($urandom_range(0, 4))
        0: ra = '0;
        1: rb = '0;
        2: ra = 32'h80000000;
        3: rb = 32'h80000000;
        default: ;
      endcase
      launch(ra, rb, rs);
      finish_op(ra, rb, rs);
      if (n % 3 != 0) pulse_end();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips32_mul_unit.md
MIPS32_MUL_UNIT -- requirements
Module: mips32_mul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk1, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled on rising edge of clk1.
REQ-005 SHALL have port signed_op, input, 1, 1 = operands are two's complement; 0 = operands are unsigned.
REQ-006 SHALL have port a, input, WIDTH, multiplicand.
REQ-007 SHALL have port b, input, WIDTH, multiplier.
REQ-008 SHALL have port busy, output, 1, operation in progress.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port lo, output, WIDTH, low half of the product (the MUL rd value).
REQ-011 SHALL have port hi, output, WIDTH, high half of the product.
REQ-012 SHALL have port ovf, output, 1, product does not fit in WIDTH bits.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: busy=0, done=0; start=1 SHALL capture a, b, signed_op, clear the accumulator and iteration counter, and go to RUN.
REQ-015 SHALL, in signed mode, convert each operand to its magnitude at capture and record sign = a[MSB] XOR b[MSB].
REQ-016 RUN: busy=1; each cycle SHALL perform one shift-add iteration on one multiplier bit, LSB first, using a 2*WIDTH accumulator.
REQ-017 SHALL go from RUN to DONE after exactly WIDTH iterations; the counter SHALL be log2(WIDTH)+1 bits wide with no wrap before the terminal count.
REQ-018 Latency: if start is accepted at edge E, done SHALL be 1 during the cycle after edge E+WIDTH, i.e. 33 cycles for WIDTH=32.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle; {hi,lo} SHALL be loaded at the DONE entry edge, two's-complement negated if sign=1.
REQ-020 In DONE, start=1 SHALL be accepted exactly as in IDLE (back-to-back operation); otherwise the FSM SHALL go to IDLE.
REQ-021 hi, lo, and ovf SHALL hold their values from the DONE entry edge until the next DONE entry or reset; they SHALL NOT change during RUN.
REQ-022 start asserted during RUN SHALL be ignored, with no effect on the operation in progress.
REQ-023 Inputs a, b, and signed_op SHALL be don't-care after the capture edge.
REQ-024 ovf, unsigned mode: ovf = (hi != 0).
REQ-025 ovf, signed mode: ovf = (hi is not the sign-extension of lo[WIDTH-1]).
REQ-026 A zero operand SHALL still take the full WIDTH iterations, giving hi=lo=0 and ovf=0.
REQ-027 Signed most-negative operand: magnitude SHALL be computed in WIDTH+1 bits or equivalent so that -2^(WIDTH-1) is exact.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE and set busy=0, done=0, hi=0, lo=0, ovf=0, and clear the counter and accumulator.
REQ-029 reset SHALL take priority over start and over any RUN or DONE activity; a reset mid-operation SHALL abort it with no done pulse.
REQ-030 The first start SHALL be accepted at the first edge where reset=0.

Verification
REQ-031 Unsigned: a=27, b=3, start for 1 cycle -> busy for 32 cycles; done at cycle 33; lo=81, hi=0, ovf=0.
REQ-032 Signed: a=-7 (0xFFFFFFF9), b=6 -> lo=0xFFFFFFD6, hi=0xFFFFFFFF, ovf=0; unsigned: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, ovf=1.
REQ-033 Signed: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, ovf=1.
REQ-034 Start a=5, b=5; pulse start again at cycle 10 with a=9, b=9 -> ignored; single done pulse with lo=25. Then start again in the DONE cycle with a=2, b=3 -> next done 33 cycles later with lo=6.
REQ-035 Reset asserted at RUN cycle 15 -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows. A new start after reset completes normally.
REQ-036 Power chain: feed each lo back as a with b=3, starting from a=1, four times -> results 3, 9, 27, 81, each with a one-cycle done pulse.
